// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package imem_loader_pkg;

    // Default instruction memory capacity, in 32-bit words.
    localparam int unsigned DEPTH_DEFAULT  = 1024;

    // Default width of the byte address driven to the memory (matches pc).
    localparam int unsigned ADDR_W_DEFAULT = 32;

    // Word index to byte address: a word is 4 bytes.
    localparam int unsigned WORD_SHIFT     = 2;

    // Loader FSM states.
    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// Byte k of a word lands in bits [8k+7:8k]; o_word_valid pulses for one
// cycle on the edge after the 4th byte is taken, with o_word holding the
// completed word during that cycle.
module imem_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_strobe,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_word_valid;

    // Byte lane counter and shift register; the counter wraps 3 -> 0 on each completed word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt        <= 2'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_strobe) begin
                r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
                r_cnt                        <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: takes a 4-byte little-endian word count and then
// the program bytes from the host, writes each packed word to instruction
// memory at byte address 4*i, and holds the CPU in reset until the last write
// has landed.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_LEN   | collecting the 4 header bytes (word count, LSB first)
// S_DATA  | collecting program bytes, one memory write per packed word
// S_FLUSH | one quiet cycle so the final write lands before release
// S_DONE  | program loaded, CPU released; terminal until reset
// S_ERR   | header count exceeded memory depth; terminal until reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_reset,
    output logic              o_load_done,
    output logic              o_load_err
);

    // Wide enough that a word index equal to DEPTH is representable.
    localparam int WIDX_W = $clog2(DEPTH) + 1;

    state_t             r_state;
    state_t             w_state_next;

    logic [1:0]         r_hcnt;
    logic [31:0]        r_len;
    logic [WIDX_W-1:0]  r_widx;

    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_cpu_reset;
    logic               r_load_done;
    logic               r_load_err;

    logic               w_accept;
    logic               w_hdr_byte;
    logic               w_hdr_last;
    logic               w_data_byte;
    logic [31:0]        w_len_full;
    logic [31:0]        w_word;
    logic               w_word_valid;
    logic               w_write;
    logic               w_last_word;
    logic [ADDR_W-1:0]  w_word_addr;

    // in_ready is a pure function of the state register.
    assign o_in_ready  = (r_state == S_LEN) || (r_state == S_DATA);

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_hdr_byte  = w_accept && (r_state == S_LEN);
    assign w_hdr_last  = w_hdr_byte && (r_hcnt == 2'd3);
    assign w_data_byte = w_accept && (r_state == S_DATA);

    // Header shifts in from the top so the first byte ends up in bits [7:0].
    assign w_len_full  = {i_in_data, r_len[31:8]};

    // A completed word is only written while still loading; a stray byte taken
    // on the last S_DATA cycle never completes a word.
    assign w_write     = w_word_valid && (r_state == S_DATA);
    assign w_last_word = w_write && ((32'(r_widx) + 32'd1) == r_len);
    assign w_word_addr = ADDR_W'(r_widx) << WORD_SHIFT;

    imem_loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_strobe     (w_data_byte),
        .i_byte       (i_in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the length decision uses the full 32-bit header value.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_LEN: begin
                if (w_hdr_last) begin
                    if (w_len_full == 32'd0) begin
                        w_state_next = S_DONE;
                    end else if (w_len_full > 32'(DEPTH)) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_last_word) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_DONE;
            S_ERR:   w_state_next = S_ERR;
            default: w_state_next = S_LEN;
        endcase
    end

    // Header capture and word index bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hcnt <= 2'd0;
            r_len  <= 32'd0;
            r_widx <= '0;
        end else begin
            if (w_hdr_byte) begin
                r_hcnt <= r_hcnt + 2'd1;
                r_len  <= w_len_full;
            end
            if (w_write) begin
                r_widx <= r_widx + 1'b1;
            end
        end
    end

    // Registered memory write port; address and data hold after the last write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_mem_we <= w_write;
            if (w_write) begin
                r_mem_addr  <= w_word_addr;
                r_mem_wdata <= w_word;
            end
        end
    end

    // Registered status outputs, one cycle behind the state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_cpu_reset <= (r_state != S_DONE);
            r_load_done <= (r_state == S_DONE);
            r_load_err  <= (r_state == S_ERR);
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_reset = r_cpu_reset;
    assign o_load_done = r_load_done;
    assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: byte streams are driven with random gaps, the
// write port is monitored, and results are compared against a reference model
// computed directly from the header/packing rules.
module tb_imem_loader;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_reset (cpu_reset),
        .o_load_done (load_done),
        .o_load_err  (load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus, observations and model expectations.
    logic [7:0]  stream_q[$];
    int          acc_q[$];
    logic [31:0] w_addr_q[$];
    logic [31:0] w_data_q[$];
    int          w_cyc_q[$];
    int          done_cyc, err_cyc, fall_cyc;
    bit          mon_en = 1'b0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_len;
    bit          exp_err;

    // Monitor: samples on the falling edge; cyc is the index of the last rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we === 1'b1) begin
                w_addr_q.push_back(mem_addr);
                w_data_q.push_back(mem_wdata);
                w_cyc_q.push_back(cyc);
            end
            if (load_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (load_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
            if (cpu_reset === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        w_addr_q.delete();
        w_data_q.delete();
        w_cyc_q.delete();
        acc_q.delete();
        done_cyc = -1;
        err_cyc  = -1;
        fall_cyc = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        mon_en   = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_mon();
        mon_en = 1'b1;
    endtask

    // Reference model: header is a little-endian word count, word i is
    // bytes 4+4i..7+4i little-endian, written at byte address 4*i.
    task automatic build_model();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_len = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
        exp_err = (exp_len > 32'(DEPTH));
        if (!exp_err) begin
            for (int i = 0; i < int'(exp_len); i++) begin
                exp_addr_q.push_back(32'(i * 4));
                exp_data_q.push_back({stream_q[4*i+7], stream_q[4*i+6],
                                      stream_q[4*i+5], stream_q[4*i+4]});
            end
        end
    endtask

    task automatic set_stream_random(input int unsigned nwords);
        logic [31:0] len;
        len = 32'(nwords);
        stream_q.delete();
        for (int i = 0; i < 4; i++) stream_q.push_back(len[8*i +: 8]);
        for (int i = 0; i < int'(nwords) * 4; i++) stream_q.push_back(8'($urandom));
    endtask

    // Drive every byte of stream_q once; records the rising edge that accepts each byte.
    task automatic drive_stream(input int gmin, input int gmax);
        int g;
        for (int i = 0; i < stream_q.size(); i++) begin
            g = (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
            repeat (g) @(negedge clk);
            in_valid = 1'b1;
            in_data  = stream_q[i];
            if (in_ready === 1'b1) acc_q.push_back(cyc + 1);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic wait_end(output bit timed_out);
        timed_out = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (load_done === 1'b1 || load_err === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
        checks++; if (mem_we !== 1'b0)     begin failures++; $display("FAIL reset mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'd0)  begin failures++; $display("FAIL reset mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (cpu_reset !== 1'b1)  begin failures++; $display("FAIL reset cpu_reset got=%b exp=1", cpu_reset); end
        checks++; if (load_done !== 1'b0)  begin failures++; $display("FAIL reset load_done got=%b exp=0", load_done); end
        checks++; if (load_err !== 1'b0)   begin failures++; $display("FAIL reset load_err got=%b exp=0", load_err); end
        in_valid = 1'b0;
    endtask

    // Full load of stream_q (len >= 1, within depth) with byte gaps in [gmin, gmax].
    task automatic test_load(input string name, input int gmin, input int gmax);
        bit to;
        int n;
        int last;
        apply_reset();
        build_model();
        drive_stream(gmin, gmax);
        wait_end(to);
        checks++; if (to) begin failures++; $display("FAIL %s done_timeout got=none exp=load_done", name); end
        checks++; if (acc_q.size() != stream_q.size()) begin
            failures++; $display("FAIL %s accepted got=%0d exp=%0d", name, acc_q.size(), stream_q.size());
        end
        checks++; if (w_data_q.size() != exp_data_q.size()) begin
            failures++; $display("FAIL %s write_count got=%0d exp=%0d", name, w_data_q.size(), exp_data_q.size());
        end
        n = (w_data_q.size() < exp_data_q.size()) ? w_data_q.size() : exp_data_q.size();
        for (int i = 0; i < n; i++) begin
            checks++; if (w_addr_q[i] !== exp_addr_q[i]) begin
                failures++; $display("FAIL %s addr[%0d] got=%h exp=%h", name, i, w_addr_q[i], exp_addr_q[i]);
            end
            checks++; if (w_data_q[i] !== exp_data_q[i]) begin
                failures++; $display("FAIL %s wdata[%0d] got=%h exp=%h", name, i, w_data_q[i], exp_data_q[i]);
            end
            if (4*i+7 < acc_q.size()) begin
                checks++; if (w_cyc_q[i] != acc_q[4*i+7] + 1) begin
                    failures++; $display("FAIL %s we_latency[%0d] got_edge=%0d exp_edge=%0d", name, i, w_cyc_q[i], acc_q[4*i+7] + 1);
                end
            end
        end
        if (w_cyc_q.size() > 0) begin
            last = w_cyc_q[w_cyc_q.size()-1];
            checks++; if (done_cyc != last + 2) begin
                failures++; $display("FAIL %s done_timing got_edge=%0d exp_edge=%0d", name, done_cyc, last + 2);
            end
            checks++; if (fall_cyc != last + 2) begin
                failures++; $display("FAIL %s cpu_release got_edge=%0d exp_edge=%0d", name, fall_cyc, last + 2);
            end
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL %s in_ready_done got=%b exp=0", name, in_ready); end
        checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL %s load_err got=%b exp=0", name, load_err); end
    endtask

    task automatic test_len_zero();
        bit to;
        stream_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        apply_reset();
        drive_stream(0, 1);
        wait_end(to);
        checks++; if (to) begin failures++; $display("FAIL len0 done_timeout got=none exp=load_done"); end
        checks++; if (w_data_q.size() != 0) begin failures++; $display("FAIL len0 write_count got=%0d exp=0", w_data_q.size()); end
        checks++; if (acc_q.size() != 4) begin failures++; $display("FAIL len0 accepted got=%0d exp=4", acc_q.size()); end
        else begin
            checks++; if (fall_cyc != acc_q[3] + 1) begin
                failures++; $display("FAIL len0 cpu_release got_edge=%0d exp_edge=%0d", fall_cyc, acc_q[3] + 1);
            end
        end
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL len0 load_done got=%b exp=1", load_done); end
        checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL len0 in_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_len_err();
        logic [31:0] lens[3];
        bit to;
        lens[0] = 32'(DEPTH + 1);
        lens[1] = 32'h8000_0000;
        lens[2] = 32'h0001_0001;
        for (int k = 0; k < 3; k++) begin
            stream_q.delete();
            for (int i = 0; i < 4; i++) stream_q.push_back(lens[k][8*i +: 8]);
            for (int i = 0; i < 4; i++) stream_q.push_back(8'($urandom));
            apply_reset();
            drive_stream(0, 1);
            wait_end(to);
            checks++; if (load_err !== 1'b1)  begin failures++; $display("FAIL err%0d load_err got=%b exp=1", k, load_err); end
            checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL err%0d in_ready got=%b exp=0", k, in_ready); end
            checks++; if (cpu_reset !== 1'b1 || fall_cyc != -1) begin
                failures++; $display("FAIL err%0d cpu_reset got=%b fall_edge=%0d exp=held_high", k, cpu_reset, fall_cyc);
            end
            checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL err%0d load_done got=%b exp=0", k, load_done); end
            checks++; if (w_data_q.size() != 0) begin failures++; $display("FAIL err%0d write_count got=%0d exp=0", k, w_data_q.size()); end
            checks++; if (acc_q.size() != 4) begin failures++; $display("FAIL err%0d accepted got=%0d exp=4", k, acc_q.size()); end
            else begin
                checks++; if (err_cyc != acc_q[3] + 1) begin
                    failures++; $display("FAIL err%0d err_timing got_edge=%0d exp_edge=%0d", k, err_cyc, acc_q[3] + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        bit to;
        logic [31:0] w0;
        stream_q = '{8'h03, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) stream_q.push_back(8'($urandom));
        w0 = {stream_q[7], stream_q[6], stream_q[5], stream_q[4]};
        apply_reset();
        drive_stream(0, 0);
        repeat (2) @(negedge clk);
        checks++; if (w_data_q.size() != 1 || w_data_q[0] !== w0) begin
            failures++; $display("FAIL midrst first_word count=%0d exp_count=1 exp=%h", w_data_q.size(), w0);
        end
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            failures++; $display("FAIL midrst reset_values got rdy=%b we=%b addr=%h wd=%h exp=1,0,0,0", in_ready, mem_we, mem_addr, mem_wdata);
        end
        checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin
            failures++; $display("FAIL midrst cpu_reset got=%b done=%b exp=1,0", cpu_reset, load_done);
        end
        reset = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        stream_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        drive_stream(0, 1);
        wait_end(to);
        checks++; if (w_data_q.size() != 1) begin failures++; $display("FAIL midrst write_count got=%0d exp=1", w_data_q.size()); end
        else begin
            checks++; if (w_addr_q[0] !== 32'd0) begin failures++; $display("FAIL midrst addr got=%h exp=0", w_addr_q[0]); end
            checks++; if (w_data_q[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL midrst wdata got=%h exp=deadbeef", w_data_q[0]); end
        end
        checks++; if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++; $display("FAIL midrst done got=%b cpu_reset=%b exp=1,0", load_done, cpu_reset);
        end
    endtask

    task automatic test_extra_after_done();
        bit to;
        logic [31:0] last_addr, last_data;
        set_stream_random(2);
        apply_reset();
        build_model();
        drive_stream(0, 1);
        wait_end(to);
        last_addr = exp_addr_q[exp_addr_q.size()-1];
        last_data = exp_data_q[exp_data_q.size()-1];
        clear_mon();
        stream_q.delete();
        for (int i = 0; i < 6; i++) stream_q.push_back(8'($urandom));
        drive_stream(0, 1);
        repeat (3) @(negedge clk);
        checks++; if (acc_q.size() != 0) begin failures++; $display("FAIL extra accepted got=%0d exp=0", acc_q.size()); end
        checks++; if (w_data_q.size() != 0) begin failures++; $display("FAIL extra write_count got=%0d exp=0", w_data_q.size()); end
        checks++; if (mem_addr !== last_addr || mem_wdata !== last_data) begin
            failures++; $display("FAIL extra hold got addr=%h wd=%h exp addr=%h wd=%h", mem_addr, mem_wdata, last_addr, last_data);
        end
        checks++; if (load_done !== 1'b1 || cpu_reset !== 1'b0 || load_err !== 1'b0) begin
            failures++; $display("FAIL extra status got done=%b cpu_reset=%b err=%b exp=1,0,0", load_done, cpu_reset, load_err);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        test_load("b2b", 0, 0);
        test_load("gap3", 3, 3);
        for (int r = 0; r < 6; r++) begin
            set_stream_random($urandom_range(8, 1));
            test_load("random", 0, 2);
        end
        set_stream_random(DEPTH);
        test_load("depth", 0, 0);
        test_len_zero();
        test_len_err();
        test_reset_mid_load();
        test_extra_after_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
